cache_refill_ctrl: RTL

- Miss-side refill engine for the 4-way, 128-set, 64-byte-line cache.
- Accepts a miss request, chooses a victim way, issues one AXI4 INCR read burst for the line, and streams the beats into the data array.
- Then drives the tagstore write port (write_en/write_index/target_way/new_tag) and signals completion.
- It is the producer for the tag array's fill interface. Clean lines only; victim write-back is out of scope.

---
 rtl/cache_refill_ctrl_pkg.sv | 37 +++
 rtl/cache_refill_ctrl_victim_select.sv | 28 ++
 rtl/cache_refill_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cache_refill_ctrl_pkg.sv
// Shared widths, AXI constants and types for the cache refill path
// (4-way, 128-set, 64-byte lines).
package cache_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int TAG_W      = 19;
    localparam int IDX_W      = 7;
    localparam int OFF_W      = 6;
    localparam int WAYS       = 4;
    localparam int WAY_W      = 2;
    localparam int LINE_BYTES = 64;
    localparam int BEATS      = LINE_BYTES / (DATA_W / 8);
    localparam int CNT_W      = 4;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [7:0] AXI_LEN    = 8'(BEATS - 1);
    localparam logic [2:0] AXI_SIZE   = 3'd2;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [WAY_W-1:0] way_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_RD   = 3'd2,
        ST_TAG  = 3'd3,
        ST_DONE = 3'd4
    } refill_state_e;

    function automatic logic [ADDR_W-1:0] line_addr(input tag_t tag, input idx_t idx);
        return {tag, idx, {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_refill_ctrl_victim_select.sv
// Victim way choice: lowest invalid way wins; a full set falls back to the
// set's round-robin pointer.
module victim_select
    import cache_pkg::*;
(
    input  logic [WAYS-1:0] valid_i,
    input  way_t            rr_ptr_i,
    output way_t            way_o,
    output logic            use_rr_o
);

    // Priority encode the first invalid way.
    always_comb begin
        way_o    = rr_ptr_i;
        use_rr_o = 1'b0;
        casez (valid_i)
            4'b???0: way_o = 2'd0;
            4'b??01: way_o = 2'd1;
            4'b?011: way_o = 2'd2;
            4'b0111: way_o = 2'd3;
            default: begin
                way_o    = rr_ptr_i;
                use_rr_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-side refill engine: picks a victim, fetches the line with one AXI4
// INCR burst into the data array, then writes the tag and reports completion.
module cache_refill_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic [WAYS-1:0]   valid_in,
    output logic              miss_ready,
    output logic              refill_done,
    output logic              refill_err,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic              data_we,
    output logic [IDX_W-1:0]  data_index,
    output logic [1:0]        data_way,
    output logic [3:0]        data_word,
    output logic [DATA_W-1:0] data_wdata,
    output logic              write_en,
    output logic [IDX_W-1:0]  write_index,
    output logic [1:0]        target_way,
    output logic [TAG_W-1:0]  new_tag
);

    refill_state_e state_q, state_d;
    tag_t          tag_q, tag_d;
    idx_t          idx_q, idx_d;
    way_t          victim_q, victim_d;
    logic          use_rr_q, use_rr_d;
    logic          err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    way_t          rr_q [1 << IDX_W];

    idx_t          req_idx_s;
    tag_t          req_tag_s;
    way_t          vs_way_s;
    logic          vs_use_rr_s;
    logic          beat_err_s;
    logic          last_beat_s;
    logic          unused_off_s;

    assign req_idx_s    = miss_addr[OFF_W +: IDX_W];
    assign req_tag_s    = miss_addr[ADDR_W-1 -: TAG_W];
    assign unused_off_s = ^miss_addr[OFF_W-1:0];

    victim_select u_victim_select (
        .valid_i  (valid_in),
        .rr_ptr_i (rr_q[req_idx_s]),
        .way_o    (vs_way_s),
        .use_rr_o (vs_use_rr_s)
    );

    assign last_beat_s = rlast | (cnt_q == 4'd15);
    assign beat_err_s  = (rresp != RESP_OKAY)
                       | (rlast & (cnt_q != 4'd15))
                       | (~rlast & (cnt_q == 4'd15));

    assign arlen       = AXI_LEN;
    assign arsize      = AXI_SIZE;
    assign arburst     = BURST_INCR;
    assign araddr      = line_addr(tag_q, idx_q);
    assign data_index  = idx_q;
    assign data_way    = victim_q;
    assign data_word   = cnt_q;
    assign write_index = idx_q;
    assign target_way  = victim_q;
    assign new_tag     = tag_q;

    // Strobes derive from the state register only, so reset clears them at once.
    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        idx_d       = idx_q;
        victim_d    = victim_q;
        use_rr_d    = use_rr_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        miss_ready  = 1'b0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        data_we     = 1'b0;
        data_wdata  = {DATA_W{1'b0}};
        write_en    = 1'b0;
        refill_done = 1'b0;
        refill_err  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                miss_ready = 1'b1;
                if (miss_req) begin
                    tag_d    = req_tag_s;
                    idx_d    = req_idx_s;
                    victim_d = vs_way_s;
                    use_rr_d = vs_use_rr_s;
                    cnt_d    = 4'd0;
                    err_d    = 1'b0;
                    state_d  = ST_AR;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_AR: begin
                arvalid = 1'b1;
                state_d = arready ? ST_RD : ST_AR;
            end
            ST_RD: begin
                rready = 1'b1;
                if (rvalid) begin
                    data_we    = 1'b1;
                    data_wdata = rdata;
                    cnt_d      = cnt_q + 4'd1;
                    err_d      = err_q | beat_err_s;
                    if (last_beat_s) begin
                        state_d = (err_q | beat_err_s) ? ST_DONE : ST_TAG;
                    end else begin
                        state_d = ST_RD;
                    end
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_TAG: begin
                write_en = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                refill_done = 1'b1;
                refill_err  = err_q;
                err_d       = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            tag_q    <= '0;
            idx_q    <= '0;
            victim_q <= '0;
            use_rr_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            idx_q    <= idx_d;
            victim_q <= victim_d;
            use_rr_q <= use_rr_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Per-set round-robin pointers advance only when a full set was refilled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < (1 << IDX_W); i++) begin
                rr_q[i] <= 2'd0;
            end
        end else if ((state_q == ST_TAG) && use_rr_q) begin
            rr_q[idx_q] <= rr_q[idx_q] + 2'd1;
        end
    end

endmodule
